// File: rtl/mem_stage_sized_pkg.sv
// Shared types for the sized MEM stage: transfer sizes, FSM states and the latched op.
package mem_stage_sized_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} mem_size_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mem_state_t;

  typedef struct packed {
    logic      write;
    mem_size_t size;
    logic      sign;
  } mem_op_t;

  // Bytes moved by an access, clamped to the datapath width.
  function automatic int size_bytes(input mem_size_t sz, input int max_bytes);
    int n;
    n = 1 << sz;
    return (n > max_bytes) ? max_bytes : n;
  endfunction

endpackage

// File: rtl/mem_stage_sized_byte_array.sv
// DEPTH-byte storage with 8 byte-lane write enables; byte addresses wrap modulo DEPTH.
module mem_byte_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [7:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [DEPTH];

  // AW-bit index arithmetic gives the DEPTH-1 -> 0 wrap for free.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (we[i]) mem[addr + AW'(i)] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem[addr + AW'(i)];
  end

endmodule

// File: rtl/mem_stage_sized.sv
// Multi-cycle sized data-memory access stage (IDLE/BUSY/DONE).
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of executing.
module mem_stage_sized
  import mem_stage_sized_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_stall,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              mem_rdata_valid,
  output logic              mem_fault,
  output mem_state_t        dbg_state
);

  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_t        state;
  mem_op_t           op;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CW-1:0]     cnt;
  logic [7:0]        we;
  logic [63:0]       rdata;
  logic [DATA_W-1:0] ext;
  logic              request;
  logic              access_now;
  logic              trap;
  logic              sign_bit;
  logic              addr_unused;
  int                nb;

  // Handshake: a request is taken only in IDLE when mem_valid & (read|write);
  // upstream holds its inputs for as long as mem_stall is high.
  assign request     = mem_valid & (mem_read | mem_write);
  assign mem_stall   = ((state == IDLE) & request) | (state == BUSY);
  assign access_now  = (state == BUSY) && (cnt == '0) && !rst;
  assign dbg_state   = state;
  assign addr_unused = ^mem_addr[ADDR_W-1:AW];
  assign nb          = size_bytes(op.size, NB);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (addr_q & AW'((1 << op.size) - 1)) != '0;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    we = '0;
    for (int i = 0; i < 8; i++) we[i] = access_now && op.write && !trap && (i < nb);
  end

  always_comb begin
    ext      = '0;
    sign_bit = op.sign & rdata[6'(8*nb - 1)];
    for (int i = 0; i < NB; i++) ext[8*i +: 8] = (i < nb) ? rdata[8*i +: 8] : {8{sign_bit}};
  end

  mem_byte_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (we),
    .addr  (addr_q),
    .wdata (64'(wdata_q)),
    .rdata (rdata)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  logic fault_q;
  assign mem_fault = fault_q;
`else
  assign mem_fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      op              <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      cnt             <= '0;
      mem_read_data   <= '0;
      mem_rdata_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      fault_q         <= 1'b0;
`endif
    end else begin
      mem_rdata_valid <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      fault_q         <= 1'b0;
`endif
      case (state)
        IDLE: if (request) begin
          op.write <= mem_write;
          op.size  <= mem_size_t'(mem_size);
          op.sign  <= mem_signed;
          addr_q   <= mem_addr[AW-1:0];
          wdata_q  <= mem_wdata;
          cnt      <= CW'(LATENCY - 1);
          state    <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          state <= DONE;
          if (trap) begin
`ifdef MEM_MISALIGN_TRAP_EN
            fault_q <= 1'b1;
`endif
          end else if (!op.write) begin
            mem_read_data   <= ext;
            mem_rdata_valid <= 1'b1;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
        // Inputs are still stale in DONE, so nothing is accepted here.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
